skolem_exhaustive_checker: RTL and testbench

//  Sequential harness stage wrapped around a synthesized Skolem function (SKF) netlist.

---
 rtl/skolem_chk_pkg.sv | 23 ++
 rtl/skolem_settle_timer.sv | 36 +++
 rtl/skolem_exhaustive_checker.sv | 130 +++++++++++++
 tb/tb_skolem_exhaustive_checker.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/skolem_chk_pkg.sv
// rtl/skolem_chk_pkg.sv - shared types and helpers for the SKF exhaustive checker
// Purpose: state encoding for the sweep FSM and the XOR-spec predicate used by
//          every SKF harness. Exposes no ports.
package skolem_chk_pkg;

  // Widest universal-input vector spec_ok accepts; narrower callers zero-extend,
  // which does not change the reduction XOR.
  localparam int MAX_IN = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } chk_state_t;

  // True when the (x, y) pair satisfies ^{x, y} == parity.
  function automatic logic spec_ok(input logic [MAX_IN-1:0] x, input logic y,
                                   input logic parity);
    return ((^x) ^ y) == parity;
  endfunction

endpackage

// File: rtl/skolem_settle_timer.sv
// rtl/skolem_settle_timer.sv - reloadable down-counter pacing the SKF settle time
// Purpose: counts the settle cycles between driving a new vector and checking it.
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   load         reload the counter with load_value (wins over dec)
//   load_value   reload value, normally SAMPLE_LAT
//   dec          decrement by one while nonzero
//   expire       high during the last settle cycle (count == 1)
module skolem_settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         expire
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  // Flag the cycle whose decrement reaches zero so the FSM spends exactly
  // load_value cycles in SETTLE.
  assign expire = (count == W'(1));

endmodule

// File: rtl/skolem_exhaustive_checker.sv
// rtl/skolem_exhaustive_checker.sv - exhaustive XOR-spec checker for an SKF netlist
// Purpose: sweeps skf_x through all 2^N_IN assignments, samples skf_y SAMPLE_LAT
//          cycles later and checks ^{x,y} == SPEC_PARITY; reports result and first
//          counterexample.
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   start        begin a sweep (accepted only in IDLE or DONE)
//   skf_x        assignment driven into the SKF
//   skf_y        SKF output, used only in CHECK
//   busy, done   sweep in progress / sweep finished (level)
//   pass         valid with done; no failing vector seen
//   fail_count   number of failing vectors
//   cex_valid    first counterexample captured
//   cex          {y, x} of the first failing vector
module skolem_exhaustive_checker
  import skolem_chk_pkg::*;
#(
  parameter int N_IN         = 3,
  parameter int SAMPLE_LAT   = 1,
  parameter bit SPEC_PARITY  = 1'b1,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] skf_x,
  input  logic            skf_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_count,
  output logic            cex_valid,
  output logic [N_IN:0]   cex
);

  localparam int TW = (SAMPLE_LAT > 0) ? $clog2(SAMPLE_LAT + 1) : 1;

  chk_state_t     state, next_state;
  logic           accept;
  logic           in_check;
  logic           ok;
  logic           finish;
  logic           timer_load;
  logic           expire;
  logic [N_IN:0]  fail_next;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start) next_state = (SAMPLE_LAT == 0) ? CHECK : SETTLE;
      SETTLE:     if (expire) next_state = CHECK;
      CHECK: begin
        if (finish) next_state = DONE;
        else        next_state = (SAMPLE_LAT == 0) ? CHECK : SETTLE;
      end
      default:    next_state = IDLE;
    endcase
  end

  // FSM decode feeding the registered datapath.
  always_comb begin
    accept     = ((state == IDLE) || (state == DONE)) && start;
    in_check   = (state == CHECK);
    ok         = spec_ok(MAX_IN'(skf_x), skf_y, SPEC_PARITY);
    finish     = in_check && ((skf_x == '1) || (!ok && STOP_ON_FAIL));
    timer_load = accept || (in_check && !finish);
    fail_next  = ok ? fail_count : fail_count + (N_IN + 1)'(1);
  end

  generate
    if (SAMPLE_LAT > 0) begin : g_timer
      skolem_settle_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (timer_load),
        .load_value (TW'(SAMPLE_LAT)),
        .dec        (state == SETTLE),
        .expire     (expire)
      );
    end else begin : g_no_timer
      assign expire = 1'b1;
    end
  endgenerate

  // Registered outputs; skf_y reaches them only through CHECK-cycle flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skf_x      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      cex_valid  <= 1'b0;
      cex        <= '0;
    end else if (accept) begin
      skf_x      <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_count <= '0;
      cex_valid  <= 1'b0;
      cex        <= '0;
    end else if (in_check) begin
      fail_count <= fail_next;
      if (!ok && !cex_valid) begin
        cex       <= {skf_y, skf_x};
        cex_valid <= 1'b1;
      end
      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
        // Uses the updated count so a failure in the final CHECK is reflected.
        pass <= (fail_next == '0);
      end else begin
        skf_x <= skf_x + N_IN'(1);
      end
    end
  end

endmodule

// File: tb/tb_skolem_exhaustive_checker.sv
// tb/tb_skolem_exhaustive_checker.sv - self-checking bench for skolem_exhaustive_checker
module tb_skolem_exhaustive_checker;

  // Instance 0: defaults; 1: STOP_ON_FAIL=1; 2: SAMPLE_LAT=0 with combinational model.
  typedef struct packed {
    logic [31:0] lat;
    logic [9:0]  res;   // {fail_count, pass, cex_valid, cex}
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] start_v = 3'b000;
  int         mode_v [3];

  logic [2:0] x_v   [3];
  logic [3:0] fc_v  [3];
  logic [3:0] cex_v [3];
  logic       busy_v [3];
  logic       done_v [3];
  logic       pass_v [3];
  logic       cv_v   [3];
  logic       y0, y1, y2;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  skolem_exhaustive_checker u_dut (
    .clk(clk), .rst(rst), .start(start_v[0]), .skf_x(x_v[0]), .skf_y(y0),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .fail_count(fc_v[0]),
    .cex_valid(cv_v[0]), .cex(cex_v[0]));

  skolem_exhaustive_checker #(.STOP_ON_FAIL(1'b1)) u_stop (
    .clk(clk), .rst(rst), .start(start_v[1]), .skf_x(x_v[1]), .skf_y(y1),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .fail_count(fc_v[1]),
    .cex_valid(cv_v[1]), .cex(cex_v[1]));

  skolem_exhaustive_checker #(.SAMPLE_LAT(0)) u_comb (
    .clk(clk), .rst(rst), .start(start_v[2]), .skf_x(x_v[2]), .skf_y(y2),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .fail_count(fc_v[2]),
    .cex_valid(cv_v[2]), .cex(cex_v[2]));

  // SKF behavioural models: 0 correct (~^x), 1 stuck-at-0, 2 always wrong (^x),
  // 3 correct except x=110 which gets the wrong value.
  function automatic logic model_y(input int mode, input logic [2:0] x);
    case (mode)
      0:       return ~^x;
      1:       return 1'b0;
      2:       return ^x;
      default: return (x == 3'b110) ? ^x : ~^x;
    endcase
  endfunction

  always @(posedge clk) begin
    y0 <= model_y(mode_v[0], x_v[0]);
    y1 <= model_y(mode_v[1], x_v[1]);
  end
  always_comb y2 = model_y(mode_v[2], x_v[2]);

  function automatic exp_t predict(input int mode, input int lat, input bit stop);
    exp_t       e;
    logic [3:0] fc = 4'd0;
    logic       cv = 1'b0;
    logic [3:0] cx = 4'd0;
    int         n  = 0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] x = 3'(i);
      logic       y = model_y(mode, x);
      logic       good = (((^x) ^ y) == 1'b1);
      n++;
      if (!good) begin
        fc++;
        if (!cv) begin
          cx = {y, x};
          cv = 1'b1;
        end
        if (stop) break;
      end
    end
    e.lat = 32'(n * (lat + 1));
    e.res = {fc, (fc == 4'd0), cv, cx};
    return e;
  endfunction

  function automatic logic [9:0] observe(input int sel);
    return {fc_v[sel], pass_v[sel], cv_v[sel], cex_v[sel]};
  endfunction

  task automatic kick(input int sel, input bit hold);
    @(negedge clk);
    start_v[sel] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_v[sel] = 1'b0;
  endtask

  task automatic wait_done(input int sel, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done_v[sel] && lat < 200);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      logic [16:0] all = {x_v[s], busy_v[s], done_v[s], observe(s)};
      n_checks++;
      if (all !== 17'd0) begin
        n_fail++;
        $display("FAIL reset_outputs inst%0d got %h exp 0", s, all);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sweep(input string name, input int sel, input int mode,
                            input int lat_cfg, input bit stop);
    exp_t e;
    int   lat;
    mode_v[sel] = mode;
    exp_q.push_back(predict(mode, lat_cfg, stop));
    kick(sel, 1'b0);
    wait_done(sel, lat);
    e = exp_q.pop_front();
    n_checks++;
    if (lat !== int'(e.lat)) begin
      n_fail++;
      $display("FAIL %s latency got %0d exp %0d", name, lat, e.lat);
    end
    n_checks++;
    if ({busy_v[sel], observe(sel)} !== {1'b0, e.res}) begin
      n_fail++;
      $display("FAIL %s result got %h exp %h", name, {busy_v[sel], observe(sel)},
               {1'b0, e.res});
    end
  endtask

  task automatic test_stop_on_fail();
    test_sweep("stop_on_fail", 1, 2, 1, 1'b1);
    n_checks++;
    if (x_v[1] !== 3'b000) begin
      n_fail++;
      $display("FAIL stop_on_fail skf_x got %b exp 000", x_v[1]);
    end
  endtask

  task automatic test_mid_reset();
    mode_v[0] = 1;
    kick(0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({x_v[0], busy_v[0], done_v[0], observe(0)} !== 15'd0) begin
      n_fail++;
      $display("FAIL mid_reset got %h exp 0", {x_v[0], busy_v[0], done_v[0], observe(0)});
    end
    @(negedge clk);
    rst = 1'b0;
    test_sweep("after_reset", 0, 1, 1, 1'b0);
  endtask

  task automatic test_start_held();
    exp_t e;
    int   lat;
    mode_v[0] = 0;
    exp_q.push_back(predict(0, 1, 1'b0));
    kick(0, 1'b1);
    wait_done(0, lat);
    start_v[0] = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (lat !== int'(e.lat) || observe(0) !== e.res) begin
      n_fail++;
      $display("FAIL start_held got lat %0d res %h exp lat %0d res %h",
               lat, observe(0), e.lat, e.res);
    end
  endtask

  task automatic test_restart_from_done();
    exp_t e;
    int   lat;
    test_sweep("restart_first", 0, 1, 1, 1'b0);
    mode_v[0] = 0;
    exp_q.push_back(predict(0, 1, 1'b0));
    kick(0, 1'b0);
    n_checks++;
    if ({busy_v[0], done_v[0], x_v[0], observe(0)} !== {1'b1, 1'b0, 3'b000, 10'd0}) begin
      n_fail++;
      $display("FAIL restart_clear got %h exp %h",
               {busy_v[0], done_v[0], x_v[0], observe(0)}, {1'b1, 1'b0, 3'b000, 10'd0});
    end
    wait_done(0, lat);
    e = exp_q.pop_front();
    n_checks++;
    if (lat !== int'(e.lat) || observe(0) !== e.res) begin
      n_fail++;
      $display("FAIL restart_second got lat %0d res %h exp lat %0d res %h",
               lat, observe(0), e.lat, e.res);
    end
  endtask

  initial begin
    mode_v[0] = 0;
    mode_v[1] = 0;
    mode_v[2] = 0;
    test_reset();
    test_sweep("correct_skf", 0, 0, 1, 1'b0);
    test_sweep("stuck_zero", 0, 1, 1, 1'b0);
    test_sweep("all_wrong", 0, 2, 1, 1'b0);
    test_stop_on_fail();
    test_sweep("single_fault", 0, 3, 1, 1'b0);
    test_mid_reset();
    test_start_held();
    test_restart_from_done();
    test_sweep("comb_correct", 2, 0, 0, 1'b0);
    test_sweep("comb_fault", 2, 3, 0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
